// File: rtl/mem_access_ctrl.sv
// Memory access controller: CPU load/store to a synchronous single-port memory.
// Optional misaligned-access trap: define MISALIGN_TRAP_EN.
module mem_access_ctrl #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [1:0]  cpu_size,
   input  logic        cpu_unsigned,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_done,
   output logic        cpu_err,
   output logic        mem_en,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCESS,
      S_WAIT,
      S_DONE
`ifdef MISALIGN_TRAP_EN
      , S_ERR
`endif
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, uns_q;
   logic [1:0]  size_q, off_q;
   logic [29:0] addr_q;
   logic [3:0]  be_q, be_c;
   logic [31:0] wdata_q, wdata_c;
   logic [31:0] rdata_q, ext_c;
   logic        en_q, mwe_q, done_q;
   logic        capture, ld_rdata, misalign;
   logic [7:0]  rd_b;
   logic [15:0] rd_h;

   // Misaligned request detection (only meaningful with the trap enabled)
`ifdef MISALIGN_TRAP_EN
   assign misalign = (cpu_size == 2'b01 && cpu_addr[0]) ||
                     (cpu_size[1] && cpu_addr[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   // Byte enables and lane-replicated write data from the live request
   always_comb begin
      be_c    = 4'b1111;
      wdata_c = cpu_wdata;
      unique case (cpu_size)
         2'b00: begin
            be_c    = 4'b0001 << cpu_addr[1:0];
            wdata_c = {4{cpu_wdata[7:0]}};
         end
         2'b01: begin
            be_c    = cpu_addr[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{cpu_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Lane extraction and sign/zero extension of the returned word
   always_comb begin
      rd_b  = mem_rdata[{off_q, 3'b000} +: 8];
      rd_h  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      ext_c = mem_rdata;
      unique case (size_q)
         2'b00: ext_c = uns_q ? {24'h0, rd_b} : {{24{rd_b[7]}}, rd_b};
         2'b01: ext_c = uns_q ? {16'h0, rd_h} : {{16{rd_h[15]}}, rd_h};
         default: ;
      endcase
   end

   // Next-state logic and wait-state counter
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      capture  = 1'b0;
      ld_rdata = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (cpu_req) begin
               capture = 1'b1;
`ifdef MISALIGN_TRAP_EN
               state_d = misalign ? S_ERR : S_ACCESS;
`else
               state_d = S_ACCESS;
`endif
            end
         end
         S_ACCESS: begin
            cnt_d   = 4'(WAIT_CYCLES);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               ld_rdata = ~we_q;
               state_d  = S_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DONE: state_d = S_IDLE;
`ifdef MISALIGN_TRAP_EN
         S_ERR: state_d = S_IDLE;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // State and counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Request capture; memory-side address/be/data held until next capture
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         size_q  <= 2'b00;
         off_q   <= 2'b00;
         addr_q  <= 30'h0;
         be_q    <= 4'h0;
         wdata_q <= 32'h0;
      end else if (capture) begin
         we_q    <= cpu_we;
         uns_q   <= cpu_unsigned;
         size_q  <= cpu_size;
         off_q   <= cpu_addr[1:0];
         addr_q  <= cpu_addr[31:2];
         be_q    <= be_c;
         wdata_q <= wdata_c;
      end
   end

   // Registered strobes, completion pulse and load data
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en_q    <= 1'b0;
         mwe_q   <= 1'b0;
         done_q  <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         en_q    <= (state_d == S_ACCESS);
         mwe_q   <= (state_d == S_ACCESS) && cpu_we;
`ifdef MISALIGN_TRAP_EN
         done_q  <= (state_d == S_DONE) || (state_d == S_ERR);
`else
         done_q  <= (state_d == S_DONE);
`endif
         if (ld_rdata) rdata_q <= ext_c;
      end
   end

`ifdef MISALIGN_TRAP_EN
   logic err_q;
   // Error flag accompanies the done pulse of a trapped request
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err_q <= 1'b0;
      else      err_q <= (state_d == S_ERR) && misalign;
   end
   assign cpu_err = err_q;
`else
   assign cpu_err = 1'b0;
`endif

   assign cpu_rdata = rdata_q;
   assign cpu_done  = done_q;
   assign mem_en    = en_q;
   assign mem_we    = mwe_q;
   assign mem_be    = be_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: vector table plus reset,
// misalignment and back-to-back sequences.
module tb_mem_access_ctrl;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_unsigned = 1'b0;
   logic [1:0]  cpu_size = 2'b10;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic [31:0] cpu_rdata, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        cpu_done, cpu_err, mem_en, mem_we;
   logic [3:0]  mem_be;
   logic [29:0] mem_addr;

   logic        req0 = 1'b0;
   logic [31:0] rdata0, wdata0;
   logic [31:0] mrd0 = 32'hCAFEF00D;
   logic        done0, err0, en0, we0;
   logic [3:0]  be0;
   logic [29:0] addr0;

   logic [31:0] mem [0:15];

   int ntot = 0;
   int npass = 0;

   always #5 clk = ~clk;

   mem_access_ctrl #(.WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_size(cpu_size), .cpu_unsigned(cpu_unsigned),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   mem_access_ctrl #(.WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .cpu_req(req0), .cpu_we(1'b0),
      .cpu_size(2'b10), .cpu_unsigned(1'b0),
      .cpu_addr(32'h20), .cpu_wdata(32'h0),
      .cpu_rdata(rdata0), .cpu_done(done0), .cpu_err(err0),
      .mem_en(en0), .mem_we(we0), .mem_be(be0),
      .mem_addr(addr0), .mem_wdata(wdata0),
      .mem_rdata(mrd0)
   );

   // Synchronous memory model: registered read, byte-lane write
   always @(posedge clk) begin
      if (mem_en) begin
         mem_rdata <= mem[mem_addr[3:0]];
         if (mem_we)
            for (int i = 0; i < 4; i++)
               if (mem_be[i])
                  mem[mem_addr[3:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd;
      logic [3:0]  be;
      logic [31:0] wd;
   } vec_t;

   vec_t tv [13];

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] e);
      ntot++;
      if (a === e) npass++;
      else $display("FAIL %s: got %h expected %h", n, a, e);
   endtask

   task automatic run(input string n, input vec_t v);
      int seen;
      int en_cnt;
      seen = 0;
      en_cnt = 0;
      @(posedge clk); #1;
      cpu_req      = 1'b1;
      cpu_we       = v.we;
      cpu_size     = v.size;
      cpu_unsigned = v.uns;
      cpu_addr     = v.addr;
      cpu_wdata    = v.wdata;
      @(posedge clk); #1;
      cpu_we       = ~v.we;
      cpu_size     = ~v.size;
      cpu_unsigned = ~v.uns;
      cpu_addr     = ~v.addr;
      cpu_wdata    = ~v.wdata;
      for (int c = 1; c <= 20 && seen == 0; c++) begin
         @(negedge clk);
         if (mem_en) en_cnt++;
         if (c == 1) begin
            chk({n, " en"}, mem_en, 1);
            chk({n, " we"}, mem_we, v.we);
            chk({n, " be"}, mem_be, v.be);
            chk({n, " wd"}, mem_wdata, v.wd);
            chk({n, " ad"}, mem_addr, v.addr[31:2]);
         end
         if (cpu_done) begin
            seen = c;
            chk({n, " lat"}, c, W + 3);
            chk({n, " rd"}, cpu_rdata, v.rd);
            chk({n, " err"}, cpu_err, 0);
            cpu_req = 1'b0;
         end
      end
      if (seen == 0) begin
         chk({n, " timeout"}, 0, 1);
         cpu_req = 1'b0;
      end
      chk({n, " encnt"}, en_cnt, 1);
   endtask

   task automatic rst_mid(input string n, input int at_c);
      int dn;
      dn = 0;
      @(posedge clk); #1;
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_size = 2'b10;
      cpu_addr = 32'h10;
      @(posedge clk);
      for (int c = 1; c <= at_c; c++) @(negedge clk);
      chk({n, " en pre"}, mem_en, (at_c == 1) ? 1 : 0);
      rst = 1'b0;
      #1;
      chk({n, " en"}, mem_en, 0);
      chk({n, " be"}, mem_be, 0);
      chk({n, " ad"}, mem_addr, 0);
      chk({n, " wd"}, mem_wdata, 0);
      chk({n, " rd"}, cpu_rdata, 0);
      chk({n, " done"}, cpu_done, 0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (cpu_done) dn++;
      end
      cpu_req = 1'b0;
      rst = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (cpu_done) dn++;
      end
      chk({n, " nodone"}, dn, 0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      mem[4] = 32'hDEADBEEF;

      tv[0]  = '{0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 4'hF, 32'h0};
      tv[1]  = '{1, 2'b00, 0, 32'h13, 32'hA5, 32'hDEADBEEF, 4'b1000,
                 32'hA5A5A5A5};
      tv[2]  = '{0, 2'b10, 0, 32'h10, 32'h0, 32'hA5ADBEEF, 4'hF, 32'h0};
      tv[3]  = '{1, 2'b10, 0, 32'h10, 32'h80017FFF, 32'hA5ADBEEF, 4'hF,
                 32'h80017FFF};
      tv[4]  = '{0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFF8001, 4'b1100, 32'h0};
      tv[5]  = '{0, 2'b01, 1, 32'h12, 32'h0, 32'h00008001, 4'b1100, 32'h0};
      tv[6]  = '{0, 2'b01, 0, 32'h10, 32'h0, 32'h00007FFF, 4'b0011, 32'h0};
      tv[7]  = '{0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFF80, 4'b1000, 32'h0};
      tv[8]  = '{0, 2'b00, 1, 32'h12, 32'h0, 32'h00000001, 4'b0100, 32'h0};
      tv[9]  = '{0, 2'b00, 0, 32'h10, 32'h0, 32'hFFFFFFFF, 4'b0001, 32'h0};
      tv[10] = '{1, 2'b01, 0, 32'h16, 32'hFFFF1234, 32'hFFFFFFFF, 4'b1100,
                 32'h12341234};
      tv[11] = '{0, 2'b11, 0, 32'h14, 32'h0, 32'h12340000, 4'hF, 32'h0};
      tv[12] = '{0, 2'b10, 1, 32'h10, 32'h0, 32'h80017FFF, 4'hF, 32'h0};

      #12;
      chk("rst en", mem_en, 0);
      chk("rst we", mem_we, 0);
      chk("rst be", mem_be, 0);
      chk("rst ad", mem_addr, 0);
      chk("rst wd", mem_wdata, 0);
      chk("rst rd", cpu_rdata, 0);
      chk("rst done", cpu_done, 0);
      chk("rst err", cpu_err, 0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 13; i++)
         run($sformatf("v%0d", i), tv[i]);

`ifdef MISALIGN_TRAP_EN
      begin
         int en_cnt;
         en_cnt = 0;
         @(posedge clk); #1;
         cpu_req  = 1'b1;
         cpu_we   = 1'b0;
         cpu_size = 2'b10;
         cpu_addr = 32'h11;
         @(posedge clk);
         @(negedge clk);
         chk("mis done", cpu_done, 1);
         chk("mis err", cpu_err, 1);
         chk("mis rd", cpu_rdata, 32'h80017FFF);
         if (mem_en) en_cnt++;
         cpu_req = 1'b0;
         for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_en) en_cnt++;
         end
         chk("mis encnt", en_cnt, 0);
      end
`else
      run("mis", '{0, 2'b10, 0, 32'h11, 32'h0, 32'h80017FFF, 4'hF, 32'h0});
`endif

      rst_mid("rstw", 2);
      rst_mid("rsta", 1);
      run("post", '{0, 2'b10, 0, 32'h10, 32'h0, 32'h80017FFF, 4'hF, 32'h0});

      @(posedge clk); #1;
      req0 = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         chk($sformatf("b2b done c%0d", c), done0, (c % 4 == 3) ? 1 : 0);
         chk($sformatf("b2b en c%0d", c), en0, (c % 4 == 1) ? 1 : 0);
         if (c == 1) begin
            chk("b2b we", we0, 0);
            chk("b2b be", be0, 4'hF);
            chk("b2b ad", addr0, 30'h8);
            chk("b2b wd", wdata0, 0);
         end
         if (c == 3) begin
            chk("b2b rd", rdata0, 32'hCAFEF00D);
            chk("b2b err", err0, 0);
         end
      end
      req0 = 1'b0;

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
